// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler: shares the I2S driver's mono sample input between
// NSRC sources. Recovers the driver frame tick into clk, pops one sample per
// frame from the active source, outputs silence on underrun and switches
// sources only at frame boundaries with a single silent frame in between.
module audio_sample_scheduler #(
    parameter int             NSRC    = 2,
    parameter int             W       = 8,
    parameter logic [W-1:0]   SILENCE = 8'h80,
    parameter int             SELW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic [NSRC-1:0]     src_valid,
    input  logic [NSRC*W-1:0]   src_data,
    output logic [NSRC-1:0]     src_ready,
    input  logic [SELW-1:0]     sel_req,
    input  logic                sel_load,
    output logic [W-1:0]        mono_sample,
    output logic [SELW-1:0]     active_src,
    output logic                switching,
    output logic                underrun,
    output logic [7:0]          underrun_count
);

    typedef enum logic [1:0] {RUN, SW_WAIT, SW_GAP} state_t;

    // Tick recovery flops: two synchroniser stages, edge history, registered pulse
    logic            sync1_q, sync2_q, edge_q, tick_q;
    logic            tick_d;

    state_t          state_q, state_d;
    logic [SELW-1:0] pending_q, pending_d;
    logic            again_q, again_d;      // new switch requested during SW_GAP
    logic [SELW-1:0] active_q, active_d;
    logic [W-1:0]    mono_q, mono_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      count_q, count_d;

    logic            cur_valid;
    logic [W-1:0]    cur_data;
    logic            sel_ok;
    logic            do_serve;
    logic            pop;

    // Rising edge of the synchronised tick; registering it gives the 4-edge latency
    always_comb begin
        tick_d = sync2_q & ~edge_q;
    end

    // Synchroniser chain and tick pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sample_tick;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            tick_q  <= tick_d;
        end
    end

    // Mux out the active source's valid and data without an oversized index
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = SILENCE;
        for (int i = 0; i < NSRC; i++) begin
            if (active_q == SELW'(i)) begin
                cur_valid = src_valid[i];
                cur_data  = src_data[i*W +: W];
            end
        end
    end

    // Switch requests to the current source or to a nonexistent one are dropped
    always_comb begin
        sel_ok = sel_load && (sel_req != active_q) && (int'(sel_req) < NSRC);
    end

    // FSM next state, frame servicing and switch bookkeeping
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        again_d    = again_q;
        active_d   = active_q;
        mono_d     = mono_q;
        underrun_d = 1'b0;
        count_d    = count_q;
        do_serve   = 1'b0;
        pop        = 1'b0;

        case (state_q)
            RUN: begin
                do_serve = tick_q;
                // A switch in the tick cycle still lets the old source serve this frame
                if (sel_ok) begin
                    pending_d = sel_req;
                    state_d   = SW_WAIT;
                end
            end
            SW_WAIT: begin
                if (sel_ok) begin
                    pending_d = sel_req;
                end
                if (tick_q) begin
                    mono_d   = SILENCE;
                    active_d = sel_ok ? sel_req : pending_q;
                    state_d  = SW_GAP;
                end
            end
            SW_GAP: begin
                do_serve = tick_q;
                if (sel_ok) begin
                    pending_d = sel_req;
                    again_d   = 1'b1;
                end
                if (tick_q) begin
                    state_d = (again_q || sel_ok) ? SW_WAIT : RUN;
                    again_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (do_serve) begin
            if (cur_valid) begin
                pop    = 1'b1;
                mono_d = cur_data;
            end else begin
                mono_d     = SILENCE;
                underrun_d = 1'b1;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pending_q  <= '0;
            again_q    <= 1'b0;
            active_q   <= '0;
            mono_q     <= SILENCE;
            underrun_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            again_q    <= again_d;
            active_q   <= active_d;
            mono_q     <= mono_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
        end
    end

    // Pop strobe goes only to the active source
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ready
        assign src_ready[gi] = pop && (active_q == SELW'(gi));
    end

    assign mono_sample    = mono_q;
    assign active_src     = active_q;
    assign switching      = (state_q != RUN);
    assign underrun       = underrun_q;
    assign underrun_count = count_q;

endmodule

// File: doc/audio_sample_scheduler.md
# audio_sample_scheduler

Shares the I2S driver's single 8-bit mono sample input between NSRC audio sources (UART stream FIFO, test tone, etc.). It synchronises the driver's frame-boundary tick into the system clock domain and pops exactly one sample from the active source per frame. It inserts silence on underrun and performs glitch-free source switching at frame boundaries. It sits between the source blocks and the driver's mono_sample input.

## Interface
- NSRC, 2: number of sources (2..4)
- W, 8: sample width
- SILENCE, 8'h80: value output on underrun, reset and switch gap
- SELW, 2: source index width (must satisfy 2^SELW >= NSRC)

Ports (clock and reset first):
- clk  in  1  27 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  driver frame tick, bck domain, high for one bck period (about 32 clk)
- src_valid  in  NSRC  per-source sample available
- src_data  in  NSRC*W  source i occupies bits [i*W +: W]
- src_ready  out  NSRC  one-clk pop strobe to the active source
- sel_req  in  SELW  requested source index
- sel_load  in  1  one-clk strobe: request switch to sel_req
- mono_sample  out  W  sample to the driver (registered)
- active_src  out  SELW  currently selected source
- switching  out  1  high while a switch is pending or in its silence gap
- underrun  out  1  one-clk pulse per frame serviced without data
- underrun_count  out  8  saturating underrun counter

## Operation
- Tick recovery:
  - sample_tick passes through a 2-flop synchroniser, then a rising-edge detector, producing `tick`, a one-clk pulse.
  - No other logic uses raw sample_tick.
- FSM states: RUN, SW_WAIT, SW_GAP. Reset state is RUN.
- RUN, on tick:
  - If src_valid[active_src] = 1: assert src_ready[active_src] combinationally in that cycle and load mono_sample <= slice active_src of src_data on the same edge. The transfer is valid & ready.
  - Otherwise: mono_sample <= SILENCE, pulse underrun, and increment underrun_count, saturating at 255.
- src_ready of a non-active source is never asserted.
- Switching:
  - sel_load with sel_req == active_src, or sel_req >= NSRC: ignored.
  - Any other sel_load: latch pending <= sel_req and go to SW_WAIT.
- SW_WAIT, on tick:
  - mono_sample <= SILENCE, with no pop and no underrun.
  - active_src <= pending, then go to SW_GAP.
- SW_GAP: on the next tick, service the frame exactly as RUN does with the new source, then go to RUN.
  - The result is one silent frame in every switch.
- A further sel_load while in SW_WAIT or SW_GAP overwrites pending only in SW_WAIT. In SW_GAP it starts a new switch after the current frame is serviced (SW_GAP → SW_WAIT instead of RUN).
- switching = (state != RUN).

## Timing
- Reset values (asynchronous, all outputs):
  - mono_sample = SILENCE
  - active_src = 0
  - src_ready = 0
  - underrun = 0
  - underrun_count = 0
  - switching = 0
  - synchroniser and edge flops = 0
- Latency: mono_sample updates on the 4th clk edge after sample_tick rises (2 sync + 1 edge + 1 load).
  - This is well inside the 32-clk bck period, so the driver samples the new value at its next bit_count == 0.
- Same-cycle tick and sel_load in RUN: the frame is serviced with the old source and pops it, then the FSM enters SW_WAIT. The switch gap occurs on the following tick.
- A source dropping src_valid in the tick cycle counts as underrun. No retry occurs within the frame.
- Reset asserted mid-switch: the FSM returns to RUN, active_src = 0, and pending is discarded.
- At most one pop per tick. A tick held high does not re-trigger.

## Test plan
- Reset: hold rst_n = 0 with ticks running → mono_sample = 8'h80, src_ready = 0, underrun_count = 0.
- Steady stream: source 0 always valid with data 8'h10, 8'h11, … over 5 ticks → 5 single-cycle src_ready[0] pulses, mono_sample follows 8'h10..8'h14, each value 4 clk after its tick edge.
- Underrun: src_valid[0] = 0 for 3 ticks → mono_sample = 8'h80, 3 underrun pulses, underrun_count = 3. Drive 300 ticks of underrun → count holds at 255.
- Switch: source 1 valid with 8'hA0 and sel_req = 1, sel_load during RUN → next tick outputs 8'h80 with no pops, active_src = 1. The following tick outputs 8'hA0 with a src_ready[1] pulse. switching is high across both frames.
- Simultaneous events: sel_load on the same clk as tick → old source popped that frame, gap on the next tick. sel_req = 3 with NSRC = 2 → ignored, switching stays 0.
- Reset mid-switch: assert rst_n = 0 in SW_WAIT → active_src = 0, switching = 0, and no pop to source 1 after release.
